// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and small op-decoding helpers.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative WIDTH-cycle multiply/divide unit producing the HI/LO pair, with
// MTHI/MTLO write-back. Multiply and divide share one shift register and adder.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b_mag;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div0;

  logic               w_idle;
  logic               w_accept;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_x;
  logic [WIDTH:0]     w_y;
  logic [WIDTH+1:0]   w_addsub;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;

  // The done cycle is spent in IDLE but still counts as busy.
  assign w_idle   = (r_state == IDLE) && !r_done;
  assign w_accept = w_idle && start;

  assign w_sa    = is_signed_op(op) & a[WIDTH-1];
  assign w_sb    = is_signed_op(op) & b[WIDTH-1];
  assign w_mag_a = w_sa ? -a : a;
  assign w_mag_b = w_sb ? -b : b;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = CALC;
      CALC:    if (r_cnt == CW'(1)) w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Divide compares the shifted partial remainder; multiply adds to the upper half.
  always_comb begin
    w_y = {1'b0, r_b_mag};
    if (is_div_op(r_op)) begin
      w_x      = r_acc[2*WIDTH-1:WIDTH-1];
      w_addsub = {1'b0, w_x} - {1'b0, w_y};
    end else begin
      w_x      = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
      w_addsub = {1'b0, w_x} + {1'b0, w_y};
    end
  end

  always_comb begin
    w_acc_next = r_acc;
    if (is_div_op(r_op)) begin
      if (w_addsub[WIDTH+1])
        w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
      else
        w_acc_next = {w_addsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      if (r_acc[0])
        w_acc_next = {w_addsub[WIDTH:0], r_acc[WIDTH-1:1]};
      else
        w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
    end
  end

  // Sign flags are zero for unsigned ops, so the corrections are no-ops there.
  always_comb begin
    w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    w_quo  = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (!is_div_op(r_op)) begin
      w_hi_res = w_prod[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod[WIDTH-1:0];
    end else if (r_div0) begin
      w_hi_res = r_a;
      w_lo_res = '1;
    end else begin
      w_hi_res = w_rem;
      w_lo_res = w_quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= '0;
      r_b_mag  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (w_idle && hi_wr) r_hi <= wdata;
          if (w_idle && lo_wr) r_lo <= wdata;
          if (w_accept) begin
            r_op     <= op;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_a      <= a;
            r_b_mag  <= w_mag_b;
            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
            r_cnt    <= CW'(WIDTH);
            r_div0   <= is_div_op(op) && (b == '0);
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CW'(1);
        end
        FIN: begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE) || r_done;
  assign done = r_done;
  assign div0 = r_div0;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latency, busy/done
// framing, div-by-zero, ignored start/writes while busy, and async reset abort.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int lat;
  int gaps;
  int ndone;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_wr (hi_wr),
    .lo_wr (lo_wr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge, then scramble op/operands to prove they were latched.
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic hw, input logic lw, input logic [31:0] wd);
    op = o; a = av; b = bv; hi_wr = hw; lo_wr = lw; wdata = wd; start = 1'b1;
    tick();
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    op = ~o; a = ~av; b = ~bv;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(output int l, output int g);
    l = 0;
    g = 0;
    while (done !== 1'b1 && l < 100) begin
      tick();
      l++;
      if (busy !== 1'b1) g++;
    end
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done === 1'b1) c++;
    end
  endtask

  task automatic op_result(input string tag, input logic [1:0] o,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic exp_div0);
    issue(o, av, bv, 1'b0, 1'b0, 32'h0);
    wait_done(lat, gaps);
    chk({tag, "_latency"}, lat, 32'd33);
    chk({tag, "_busy_gaps"}, gaps, 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_div0"}, {31'b0, div0}, {31'b0, exp_div0});
    $display("%s: hi=%h lo=%h div0=%0b latency=%0d", tag, hi, lo, div0, lat);
    tick();
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_busy_release"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_div0", {31'b0, div0}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    $display("reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
    rst_n = 1'b1;
    tick();

    op_result("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    op_result("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    op_result("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    op_result("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    op_result("divu_zero", OP_DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1'b1);

    issue(OP_MULTU, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0);
    chk("div0_cleared", {31'b0, div0}, 32'd0);
    wait_done(lat, gaps);
    chk("multu_3x4_hi", hi, 32'h0);
    chk("multu_3x4_lo", lo, 32'd12);
    $display("multu_3x4: hi=%h lo=%h div0=%0b latency=%0d", hi, lo, div0, lat);
    tick();

    op_result("div_minint", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

    // Second start plus MTHI while busy must both be dropped.
    issue(OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    op = OP_DIVU; a = 32'd9; b = 32'd3; start = 1'b1; hi_wr = 1'b1; wdata = 32'hAAAA;
    tick();
    start = 1'b0; hi_wr = 1'b0;
    chk("busy_hi_wr_ignored", hi, 32'h0);
    wait_done(lat, gaps);
    chk("busy_start_latency", lat, 32'd27);
    chk("busy_start_hi", hi, 32'h0);
    chk("busy_start_lo", lo, 32'd6);
    count_done(40, ndone);
    chk("busy_start_single_done", ndone, 32'd0);
    $display("ignored_start: hi=%h lo=%h extra_done=%0d", hi, lo, ndone);

    // MTHI+MTLO alongside an accepted start: written now, overwritten at completion.
    issue(OP_MULTU, 32'd4, 32'd5, 1'b1, 1'b1, 32'h77);
    chk("mt_with_start_hi", hi, 32'h77);
    chk("mt_with_start_lo", lo, 32'h77);
    wait_done(lat, gaps);
    chk("mt_then_op_hi", hi, 32'h0);
    chk("mt_then_op_lo", lo, 32'd20);
    $display("mt_with_start: hi=%h lo=%h latency=%0d", hi, lo, lat);
    tick();

    // Asynchronous reset mid-operation aborts the op.
    issue(OP_MULT, 32'd7, 32'd7, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    tick();
    rst_n = 1'b1;
    count_done(40, ndone);
    chk("abort_no_done", ndone, 32'd0);
    chk("abort_lo_held", lo, 32'h0);
    $display("reset_abort: busy=%0b hi=%h lo=%h done_seen=%0d", busy, hi, lo, ndone);

    lo_wr = 1'b1; wdata = 32'h55;
    tick();
    lo_wr = 1'b0;
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_hi", hi, 32'h0);
    $display("mtlo: hi=%h lo=%h", hi, lo);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
